mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive denied cycles for a pending instruction request.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port inst_req, input, 1 bit: fetch read request.
REQ-005 The block SHALL have port inst_addr, input, 32 bits: fetch byte address.
REQ-006 The block SHALL have port inst_cancel, input, 1 bit: pipeline flush; discard in-flight fetch response.
REQ-007 The block SHALL have port inst_addr_ok, output, 1 bit: fetch request granted this cycle.
REQ-008 The block SHALL have port inst_data_ok, output, 1 bit: inst_rdata valid this cycle.
REQ-009 The block SHALL have port inst_rdata, output, 32 bits: fetch read data.
REQ-010 The block SHALL have port data_req, input, 1 bit: load/store request.
REQ-011 The block SHALL have port data_wr, input, 1 bit: 1 for store, 0 for load.
REQ-012 The block SHALL have port data_wstrb, input, 4 bits: store byte enables.
REQ-013 The block SHALL have port data_addr, input, 32 bits: load/store byte address.
REQ-014 The block SHALL have port data_wdata, input, 32 bits: store data.
REQ-015 The block SHALL have port data_addr_ok, output, 1 bit: data request granted this cycle.
REQ-016 The block SHALL have port data_data_ok, output, 1 bit: load data valid or store completed.
REQ-017 The block SHALL have port data_rdata, output, 32 bits: load read data.
REQ-018 The block SHALL have port ram_en, output, 1 bit: shared SRAM access enable.
REQ-019 The block SHALL have port ram_wen, output, 4 bits: SRAM byte write enables.
REQ-020 The block SHALL have port ram_addr, output, 32 bits: SRAM address.
REQ-021 The block SHALL have port ram_wdata, output, 32 bits: SRAM write data.
REQ-022 The block SHALL have port ram_rdata, input, 32 bits: SRAM read data, valid one cycle after ram_en.

Function
REQ-023 The block SHALL grant at most one requester per cycle; the grant is combinational and is signalled by the matching *_addr_ok with ram_en=1 in the same cycle.
REQ-024 When both requesters are pending, data SHALL win unless starve_cnt equals STARVE_LIMIT, in which case instruction wins.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle inst_req=1 and inst is not granted; it SHALL clear on any inst grant or when inst_req=0.
REQ-026 A granted instruction request SHALL drive ram_wen=0 and ram_addr=inst_addr; a granted load SHALL drive ram_wen=0; a granted store SHALL drive ram_wen=data_wstrb and ram_wdata=data_wdata.
REQ-027 With no grant, ram_en and ram_wen SHALL be 0.
REQ-028 Response latency SHALL be exactly one cycle: the cycle after a grant, the owner's *_data_ok=1 and *_rdata=ram_rdata; a store also returns data_data_ok.
REQ-029 A response-owner FSM SHALL have states IDLE, RESP_I and RESP_D, and SHALL transition on every edge to RESP_I after an inst grant, RESP_D after a data grant, and IDLE otherwise.
REQ-030 Back-to-back grants SHALL be allowed: a response and a new grant occur in the same cycle.
REQ-031 inst_cancel=1 in state RESP_I SHALL force inst_data_ok to 0 for that response.
REQ-032 inst_cancel=1 SHALL block any inst grant in that cycle; data requests are unaffected.
REQ-033 inst_data_ok and data_data_ok SHALL never be 1 in the same cycle.
REQ-034 *_rdata SHALL be 0 whenever the matching *_data_ok is 0.

Reset
REQ-035 While resetn=0 at a clock edge, the FSM SHALL go to IDLE and starve_cnt SHALL go to 0.
REQ-036 While resetn=0, all outputs SHALL be 0 and no grant SHALL be made.
REQ-037 A response in flight across reset SHALL be dropped.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RESP_I=2'd1, RESP_D=2'd2) and the STARVE_LIMIT default.
REQ-039 The starvation counter SHALL be one sub-module, arb_starve_cnt; everything else is flat.

Verification
REQ-040 The bench SHALL drive inst_req only, inst_addr=0xBFC00000, ram_rdata=0x3C1D0001 and check inst_addr_ok, ram_en and ram_addr=0xBFC00000, with inst_data_ok=1 and inst_rdata=0x3C1D0001 the next cycle.
REQ-041 The bench SHALL hold inst_req and data_req both high for 10 cycles with STARVE_LIMIT=4 and check the grant pattern D,D,D,D,I repeating, i.e. inst granted on cycles 5 and 10.
REQ-042 The bench SHALL issue a store with data_addr=0x1000, wstrb=4'b0011, wdata=0xAABBCCDD and check ram_wen=0011 and ram_wdata=0xAABBCCDD, with data_data_ok=1 the next cycle.
REQ-043 The bench SHALL grant inst, then assert inst_cancel the next cycle with data_req=1, and check inst_data_ok=0, a data grant in the same cycle, and the FSM in RESP_D after the edge.
REQ-044 The bench SHALL drop resetn for one cycle while in RESP_D and check data_data_ok=0, all outputs 0, and starve_cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter.
//   - resp_state_e : encoding of the response-owner FSM
//   - STARVE_LIMIT_DEF : default cap on consecutive denied fetch cycles
//   - cnt_width() : width of a counter that must hold 0..limit
package mem_port_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

  // Bits needed to count from 0 up to and including limit (at least 1).
  function automatic int cnt_width(input int limit);
    if (limit < 1) begin
      return 1;
    end else begin
      return $clog2(limit + 1);
    end
  endfunction

endpackage

// File: rtl/mem_port_arb_starve_cnt.sv
// Starvation counter for the fetch requester.
// Counts consecutive cycles in which a fetch request is pending but not
// granted, saturating at LIMIT; any fetch grant or an idle fetch port clears it.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   inst_req         : fetch request pending this cycle
//   inst_grant       : fetch granted this cycle
//   at_limit         : counter has reached LIMIT (fetch must win next tie)
module arb_starve_cnt
  import mem_port_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_grant,
  output logic at_limit
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  // Next count: clear on grant or idle request, otherwise saturating increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!inst_req || inst_grant) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == LIMIT_C) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1'b1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign at_limit = (cnt_r == LIMIT_C);

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for a single-port SRAM with one-cycle read latency.
// Data accesses have priority; the fetch port wins a tie once it has been
// denied STARVE_LIMIT cycles in a row. Grants are combinational; the response
// is returned to whichever port owned the previous cycle's grant.
// Ports:
//   clk, resetn                         : clock, synchronous active-low reset
//   inst_req/inst_addr/inst_cancel      : fetch request, address, flush
//   inst_addr_ok/inst_data_ok/inst_rdata: fetch grant, response valid, data
//   data_req/wr/wstrb/addr/wdata        : load/store request
//   data_addr_ok/data_data_ok/data_rdata: data grant, response valid, data
//   ram_en/ram_wen/ram_addr/ram_wdata   : SRAM request side
//   ram_rdata                           : SRAM read data (one cycle after ram_en)
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  resp_state_e state_r;
  resp_state_e state_nxt_s;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        at_limit_s;

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .inst_grant(grant_i_s),
    .at_limit  (at_limit_s)
  );

  // Grant selection: a cancelled fetch is never granted, so data takes the
  // port even if the fetch side has reached its starvation limit.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (!resetn) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (inst_req && !inst_cancel && (!data_req || at_limit_s)) begin
      grant_i_s = 1'b1;
    end else if (data_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // SRAM request mux driven by the winning requester.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = 32'h0000_0000;
    ram_wdata = 32'h0000_0000;
    if (grant_i_s) begin
      ram_en   = 1'b1;
      ram_addr = inst_addr;
    end else if (grant_d_s) begin
      ram_en   = 1'b1;
      ram_addr = data_addr;
      if (data_wr) begin
        ram_wen   = data_wstrb;
        ram_wdata = data_wdata;
      end else begin
        ram_wen   = 4'b0000;
        ram_wdata = 32'h0000_0000;
      end
    end else begin
      ram_en = 1'b0;
    end
  end

  assign inst_addr_ok = grant_i_s;
  assign data_addr_ok = grant_d_s;

  // Response-owner state register; reset drops any response in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next owner is whoever was granted this cycle (back-to-back allowed).
  always_comb begin
    state_nxt_s = IDLE;
    if (grant_i_s) begin
      state_nxt_s = RESP_I;
    end else if (grant_d_s) begin
      state_nxt_s = RESP_D;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Response outputs; read data is forced to zero unless the port owns it.
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_r)
      RESP_I:  inst_data_ok = resetn && !inst_cancel;
      RESP_D:  data_data_ok = resetn;
      IDLE:    inst_data_ok = 1'b0;
      default: data_data_ok = 1'b0;
    endcase
    inst_rdata = inst_data_ok ? ram_rdata : 32'h0000_0000;
    data_rdata = data_data_ok ? ram_rdata : 32'h0000_0000;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, ram_rdata;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, ram_en;
  logic [31:0] inst_rdata, data_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_wen;

  always #5 clk = ~clk;

  mem_port_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  typedef struct {
    logic        rn;
    logic        ireq;
    logic        icancel;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [3:0]  wstrb;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_gi;
    logic        exp_gd;
  } vec_t;

  typedef struct {
    logic        is_inst;
    logic [31:0] rdata;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  function automatic vec_t mk(input logic rn, input logic ireq, input logic icancel,
                              input logic [31:0] iaddr, input logic dreq, input logic dwr,
                              input logic [3:0] wstrb, input logic [31:0] daddr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic gi, input logic gd);
    vec_t v;
    v.rn = rn; v.ireq = ireq; v.icancel = icancel; v.iaddr = iaddr;
    v.dreq = dreq; v.dwr = dwr; v.wstrb = wstrb; v.daddr = daddr;
    v.wdata = wdata; v.rdata = rdata; v.exp_gi = gi; v.exp_gd = gd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    resetn = v.rn; inst_req = v.ireq; inst_cancel = v.icancel; inst_addr = v.iaddr;
    data_req = v.dreq; data_wr = v.dwr; data_wstrb = v.wstrb; data_addr = v.daddr;
    data_wdata = v.wdata; ram_rdata = v.rdata;
  endtask

  // Compare all outputs for one vector against the table and the scoreboard.
  task automatic check_cycle(input vec_t v, input int i);
    resp_t       e;
    logic        eiok, edok;
    logic [31:0] eird, edrd;
    eiok = 1'b0; edok = 1'b0; eird = 32'h0; edrd = 32'h0;
    if (!v.rn) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_inst) begin
        eiok = !v.icancel;
        eird = eiok ? e.rdata : 32'h0;
      end else begin
        edok = 1'b1;
        edrd = e.rdata;
      end
    end
    chk($sformatf("v%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(v.exp_gi));
    chk($sformatf("v%0d data_addr_ok", i), 32'(data_addr_ok), 32'(v.exp_gd));
    chk($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(v.exp_gi | v.exp_gd));
    chk($sformatf("v%0d ram_wen", i), 32'(ram_wen), 32'((v.exp_gd && v.dwr) ? v.wstrb : 4'b0000));
    chk($sformatf("v%0d inst_data_ok", i), 32'(inst_data_ok), 32'(eiok));
    chk($sformatf("v%0d inst_rdata", i), inst_rdata, eird);
    chk($sformatf("v%0d data_data_ok", i), 32'(data_data_ok), 32'(edok));
    chk($sformatf("v%0d data_rdata", i), data_rdata, edrd);
    if (v.exp_gi) chk($sformatf("v%0d ram_addr_i", i), ram_addr, v.iaddr);
    if (v.exp_gd) chk($sformatf("v%0d ram_addr_d", i), ram_addr, v.daddr);
    if (v.exp_gd && v.dwr) chk($sformatf("v%0d ram_wdata", i), ram_wdata, v.wdata);
    if (!v.rn) begin
      chk($sformatf("v%0d ram_addr_rst", i), ram_addr, 32'h0);
      chk($sformatf("v%0d ram_wdata_rst", i), ram_wdata, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [1:0]  exp_state;
    int          exp_cnt;
    bit          post_chk;
    exp_state = 2'd0; exp_cnt = 0; post_chk = 1'b0;

    // rn ireq icancel iaddr dreq dwr wstrb daddr wdata rdata gi gd
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1111_1111, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h3C1D_0001, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b0, 4'h0, 32'h0000_3000,
                        32'h0, 32'hA000_0000 + 32'(k), (k % 5) == 4, (k % 5) != 4));
    end
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_1000, 32'hAABB_CCDD, 32'hB000_0001, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0002, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0003, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0404, 1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0, 32'hB000_0004, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0408, 1'b1, 1'b0, 4'h0, 32'h0000_4004, 32'h0, 32'hB000_0005, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0006, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0007, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0008, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hB000_0009, 1'b0, 1'b0));

    drive(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (post_chk) begin
        chk($sformatf("v%0d state", i), 32'(dut.state_r), 32'(exp_state));
        chk($sformatf("v%0d starve_cnt", i), 32'(dut.u_starve.cnt_r), 32'(exp_cnt));
      end
      drive(v);
      @(negedge clk);
      check_cycle(v, i);
      if (!v.rn) begin
        exp_state = IDLE;
        exp_cnt = 0;
      end else begin
        exp_state = v.exp_gi ? RESP_I : (v.exp_gd ? RESP_D : IDLE);
        if (!v.ireq || v.exp_gi) exp_cnt = 0;
        else if (exp_cnt < 4) exp_cnt++;
      end
      post_chk = 1'b1;
      if ((v.exp_gi || v.exp_gd) && (i + 1 < vecs.size())) begin
        sb_q.push_back('{is_inst: v.exp_gi, rdata: vecs[i + 1].rdata});
      end
      @(posedge clk); #1;
    end
    chk("final state", 32'(dut.state_r), 32'(exp_state));

    // Hand sequence: reset held two cycles across an in-flight fetch response.
    sb_q.delete();
    resetn = 1'b1; inst_req = 1'b1; inst_cancel = 1'b0; inst_addr = 32'h0000_0040;
    data_req = 1'b0; data_wr = 1'b0; ram_rdata = 32'h0;
    @(negedge clk);
    chk("hs grant", 32'(inst_addr_ok), 32'(1'b1));
    @(posedge clk); #1;
    resetn = 1'b0; data_req = 1'b1; ram_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("hs%0d inst_data_ok", c), 32'(inst_data_ok), 32'(1'b0));
      chk($sformatf("hs%0d inst_rdata", c), inst_rdata, 32'h0);
      chk($sformatf("hs%0d ram_en", c), 32'(ram_en), 32'(1'b0));
      chk($sformatf("hs%0d addr_ok", c), 32'({inst_addr_ok, data_addr_ok}), 32'(2'b00));
      @(posedge clk); #1;
    end
    chk("hs state", 32'(dut.state_r), 32'(IDLE));
    chk("hs starve_cnt", 32'(dut.u_starve.cnt_r), 32'h0);
    resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("hs post data_ok", 32'({inst_data_ok, data_data_ok}), 32'(2'b00));
    chk("hs post ram_en", 32'(ram_en), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
